gol_line_renderer: RTL



---
 rtl/gol_pkg.sv | 12 +
 rtl/gol_line_renderer_icon_rom.sv | 11 +
 rtl/gol_line_renderer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared board sizes, colours and fetch FSM encoding for the Game of Life display
package gol_pkg;
  localparam int LOG_WIDTH = 4;
  localparam int LOG_HEIGHT = 4;
  localparam int LOG_CELL = 3;
  localparam int CELL_PX = 1 << LOG_CELL;
  localparam logic [5:0] COL_LIVE = 6'b11_11_01;
  localparam logic [5:0] COL_BG = 6'b01_01_01;
  localparam logic [5:0] COL_BORDER = 6'b10_10_10;
  localparam logic [5:0] COL_OFF = 6'b00_00_00;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_DRAIN} fetch_state_e;
endpackage

// File: rtl/gol_line_renderer_icon_rom.sv
// gol_icon_rom: 8x8 round cell icon, one bit per (row, column)
module gol_icon_rom (
  input  logic [2:0] y,
  input  logic [2:0] x,
  output logic       pix
);
  logic [7:0] row;
  // Rows 0/7 blank, rows 1/6 narrow, middle four rows wide
  always_comb row = (y == 3'd0 || y == 3'd7) ? 8'h00 : (y == 3'd1 || y == 3'd6) ? 8'h3C : 8'h7E;
  assign pix = row[x];
endmodule

// File: rtl/gol_line_renderer.sv
// gol_line_renderer: prefetches a board row each hblank and draws it as 8x8 icons
module gol_line_renderer
  import gol_pkg::*;
#(
  parameter int logWIDTH = LOG_WIDTH,
  parameter int logHEIGHT = LOG_HEIGHT,
  parameter int FRAME_X0 = 256,
  parameter int FRAME_Y0 = 176,
  parameter int H_ACTIVE = 640
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    hpos,
  input  logic [9:0]                    vpos,
  input  logic                          display_on,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  output logic                          rd_en,
  output logic [logWIDTH+logHEIGHT-1:0] rd_addr,
  input  logic                          rd_data,
  output logic [1:0]                    R,
  output logic [1:0]                    G,
  output logic [1:0]                    B,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          fetch_busy
);
  localparam int W = 1 << logWIDTH;
  localparam logic [9:0] X0 = 10'(FRAME_X0);
  localparam logic [9:0] Y0 = 10'(FRAME_Y0);
  localparam logic [9:0] X1 = 10'(FRAME_X0 + (CELL_PX << logWIDTH));
  localparam logic [9:0] Y1 = 10'(FRAME_Y0 + (CELL_PX << logHEIGHT));
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] V_LAST = 10'd524;
  logic [9:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d, hs1_q, hs1_d, vs1_q, vs1_d;
  fetch_state_e state_q, state_d;
  logic [logHEIGHT-1:0] row_q, row_d;
  logic [logWIDTH-1:0] col_q, col_d, wcol_q, wcol_d;
  logic pend_q, pend_d;
  logic [W-1:0] lbuf_q, lbuf_d;
  logic [5:0] rgb_q, rgb_d;
  logic [9:0] nv, ndy, dx;
  logic trig, in_x, in_y, ring_x, ring_y, in_frame, ring, icon_bit, live;
  logic unused_bits;
  gol_icon_rom u_icon (.y(vpos_q[2:0]), .x(hpos_q[2:0]), .pix(icon_bit));
  // Row fetch: trigger at end of active line, 16 requests, then one drain cycle for the last read
  always_comb begin
    nv = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
    ndy = nv - Y0;
    trig = hpos_q == HA && nv >= Y0 && nv < Y1;
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    pend_d = state_q == F_REQ;
    wcol_d = col_q;
    lbuf_d = lbuf_q;
    if (pend_q) lbuf_d[wcol_q] = rd_data;
    case (state_q)
      F_IDLE: if (trig) begin
        state_d = F_REQ;
        row_d = ndy[LOG_CELL +: logHEIGHT];
        col_d = '0;
      end
      F_REQ: begin
        col_d = col_q + logWIDTH'(1);
        if (&col_q) state_d = F_DRAIN;
      end
      default: state_d = F_IDLE;
    endcase
  end
  // Pixel path: stage-0 capture, then frame/ring/icon decode into registered colour
  always_comb begin
    hpos_d = hpos;
    vpos_d = vpos;
    de_d = display_on;
    hs_d = hsync_in;
    vs_d = vsync_in;
    hs1_d = hs_q;
    vs1_d = vs_q;
    dx = hpos_q - X0;
    in_x = hpos_q >= X0 && hpos_q < X1;
    in_y = vpos_q >= Y0 && vpos_q < Y1;
    ring_x = hpos_q >= X0 - 10'd1 && hpos_q <= X1;
    ring_y = vpos_q >= Y0 - 10'd1 && vpos_q <= Y1;
    in_frame = de_q && in_x && in_y;
    ring = ring_x && ring_y && !(in_x && in_y);
    live = lbuf_q[dx[LOG_CELL +: logWIDTH]];
    rgb_d = !de_q ? COL_OFF : ring ? COL_BORDER : in_frame ? ((live && icon_bit) ? COL_LIVE : COL_BG) : COL_OFF;
  end
  // All state cleared by synchronous reset, which also aborts any fetch in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      state_q <= F_IDLE;
      row_q <= '0;
      col_q <= '0;
      wcol_q <= '0;
      pend_q <= 1'b0;
      lbuf_q <= '0;
      rgb_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      wcol_q <= wcol_d;
      pend_q <= pend_d;
      lbuf_q <= lbuf_d;
      rgb_q <= rgb_d;
    end
  end
  assign rd_en = state_q == F_REQ;
  assign rd_addr = {row_q, col_q};
  assign fetch_busy = state_q != F_IDLE;
  assign {R, G, B} = rgb_q;
  assign hsync_out = hs1_q;
  assign vsync_out = vs1_q;
  assign unused_bits = ^{dx[LOG_CELL-1:0], dx[9:LOG_CELL+logWIDTH], ndy[LOG_CELL-1:0], ndy[9:LOG_CELL+logHEIGHT]};
endmodule
